// File: rtl/hcsr04_multi_ranger.sv
// Round-robin HC-SR04 controller: triggers one sensor at a time, measures the echo
// high-time in clock ticks and keeps an IIR-smoothed value per channel.
module hcsr04_multi_ranger #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned WIDTH         = 21,
  parameter int unsigned TRIG_TICKS    = 500,
  parameter int unsigned TIMEOUT_TICKS = 1900000,
  parameter int unsigned GAP_TICKS     = 3000000,
  parameter int unsigned AVG_SHIFT     = 2,
  localparam int unsigned ID_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [N_CH-1:0]   echo_in,
  output logic [N_CH-1:0]   trig_out,
  output logic [ID_W-1:0]   ch_id,
  output logic [WIDTH-1:0]  width_ticks,
  output logic [WIDTH-1:0]  avg_ticks,
  output logic              sample_valid,
  output logic              sample_timeout,
  output logic              busy
);

  localparam int unsigned TRIG_W = $clog2(TRIG_TICKS + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_TICKS + 1);

  localparam logic [TRIG_W-1:0] TrigLast = TRIG_W'(TRIG_TICKS - 1);
  localparam logic [TMO_W-1:0]  TmoLast  = TMO_W'(TIMEOUT_TICKS - 1);
  localparam logic [GAP_W-1:0]  GapLast  = GAP_W'(GAP_TICKS - 1);
  localparam logic [ID_W-1:0]   LastCh   = ID_W'(N_CH - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StTrig, StWaitRise, StMeasure, StResult, StGap
  } state_e;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [TRIG_W-1:0]  trig_cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [GAP_W-1:0]   gap_q;
  logic [WIDTH-1:0]   width_q;
  logic               tmo_flag_q;
  logic               seen_low_q;
  logic [WIDTH-1:0]   avg_q [N_CH];
  logic [N_CH-1:0]    primed_q;
  logic [N_CH-1:0]    echo_meta_q;
  logic [N_CH-1:0]    echo_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_q <= '0;
      echo_sync_q <= '0;
    end else begin
      echo_meta_q <= echo_in;
      echo_sync_q <= echo_meta_q;
    end
  end

  logic               echo_cur;
  logic               tmo_hit;
  logic [WIDTH-1:0]   width_inc;
  logic [ID_W-1:0]    sel_idx;
  logic               sel_found;
  logic [N_CH-1:0]    sel_onehot;

  assign echo_cur  = echo_sync_q[ch_id];
  assign tmo_hit   = (tmo_q >= TmoLast);
  assign width_inc = (&width_q) ? width_q : width_q + 1'b1;

  // Descending scan so the smallest offset from the pointer is the last write.
  always_comb begin
    int cand;
    logic [ID_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      cand     = (int'(ptr_q) + i) % int'(N_CH);
      cand_idx = ID_W'(cand);
      if (ch_mask[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  logic [WIDTH-1:0]        avg_cur;
  logic [WIDTH-1:0]        avg_new;
  logic signed [WIDTH:0]   avg_diff;
  logic signed [WIDTH:0]   avg_step;

  always_comb begin
    avg_cur  = avg_q[ch_id];
    avg_diff = $signed({1'b0, width_q}) - $signed({1'b0, avg_cur});
    avg_step = avg_diff >>> AVG_SHIFT;
    avg_new  = avg_cur + avg_step[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      trig_cnt_q     <= '0;
      tmo_q          <= '0;
      gap_q          <= '0;
      width_q        <= '0;
      tmo_flag_q     <= 1'b0;
      seen_low_q     <= 1'b0;
      primed_q       <= '0;
      for (int i = 0; i < int'(N_CH); i++) avg_q[i] <= '0;
      trig_out       <= '0;
      ch_id          <= '0;
      width_ticks    <= '0;
      avg_ticks      <= '0;
      sample_valid   <= 1'b0;
      sample_timeout <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable && (|ch_mask)) begin
            state_q <= StSelect;
            busy    <= 1'b1;
          end
        end
        StSelect: begin
          if (sel_found) begin
            ch_id      <= sel_idx;
            trig_out   <= sel_onehot;
            trig_cnt_q <= '0;
            state_q    <= StTrig;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StTrig: begin
          if (trig_cnt_q == TrigLast) begin
            trig_out   <= '0;
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
            seen_low_q <= 1'b0;
            state_q    <= StWaitRise;
          end else begin
            trig_cnt_q <= trig_cnt_q + 1'b1;
          end
        end
        StWaitRise: begin
          tmo_q <= tmo_q + 1'b1;
          if (tmo_hit) begin
            width_q    <= '0;
            tmo_flag_q <= 1'b1;
            state_q    <= StResult;
          end else if (!echo_cur) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            width_q <= WIDTH'(1);
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          tmo_q <= tmo_q + 1'b1;
          if (!echo_cur) begin
            state_q <= StResult;
          end else if (tmo_hit) begin
            width_q    <= width_inc;
            tmo_flag_q <= 1'b1;
            state_q    <= StResult;
          end else begin
            width_q <= width_inc;
          end
        end
        StResult: begin
          sample_valid   <= 1'b1;
          sample_timeout <= tmo_flag_q;
          width_ticks    <= width_q;
          if (tmo_flag_q) begin
            avg_ticks <= avg_cur;
          end else if (primed_q[ch_id]) begin
            avg_q[ch_id] <= avg_new;
            avg_ticks    <= avg_new;
          end else begin
            avg_q[ch_id]    <= width_q;
            avg_ticks       <= width_q;
            primed_q[ch_id] <= 1'b1;
          end
          ptr_q   <= (ch_id == LastCh) ? '0 : ch_id + 1'b1;
          gap_q   <= '0;
          state_q <= StGap;
        end
        StGap: begin
          if (gap_q == GapLast) begin
            if (enable) begin
              state_q <= StSelect;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          trig_out <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_multi_ranger.sv
// Directed bench for hcsr04_multi_ranger: scripted echo responder, table of expected
// samples, plus reset-during-measure and mask corner sequences.
module tb_hcsr04_multi_ranger;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 21;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic [3:0]      ch_mask;
  logic [3:0]      echo_in;
  logic [3:0]      trig_out;
  logic [1:0]      ch_id;
  logic [W-1:0]    width_ticks;
  logic [W-1:0]    avg_ticks;
  logic            sample_valid;
  logic            sample_timeout;
  logic            busy;

  hcsr04_multi_ranger #(
    .N_CH          (N_CH),
    .WIDTH         (W),
    .TRIG_TICKS    (5),
    .TIMEOUT_TICKS (1000),
    .GAP_TICKS     (20),
    .AVG_SHIFT     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ch_mask        (ch_mask),
    .echo_in        (echo_in),
    .trig_out       (trig_out),
    .ch_id          (ch_id),
    .width_ticks    (width_ticks),
    .avg_ticks      (avg_ticks),
    .sample_valid   (sample_valid),
    .sample_timeout (sample_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Echo responder: on each trigger fall, pops the next pulse length from the script
  // and drives that many high cycles starting immediately.
  int   script[$];
  int   resp_t   [4];
  int   resp_len [4];
  bit   resp_on  [4];
  logic [3:0] trig_prev;

  initial begin
    echo_in   = '0;
    trig_prev = '0;
    for (int c = 0; c < 4; c++) begin
      resp_on[c] = 1'b0; resp_t[c] = 0; resp_len[c] = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (trig_prev[c] && !trig_out[c]) begin
          resp_on[c]  = 1'b1;
          resp_t[c]   = 0;
          resp_len[c] = (script.size() > 0) ? script.pop_front() : 0;
        end
        if (resp_on[c]) begin
          echo_in[c] = (resp_t[c] < resp_len[c]);
          resp_t[c]++;
          if (resp_t[c] > resp_len[c]) resp_on[c] = 1'b0;
        end
        trig_prev[c] = trig_out[c];
      end
    end
  end

  // Protocol monitor: trigger length, one-hot trigger, strobe width, busy during scan.
  int trig_run = 0, trig_pulses = 0, trig_bad = 0, onehot_viol = 0;
  int valid_run = 0, valid_cnt = 0, valid_long = 0, busy_drop = 0;
  bit scan_watch = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trig_run  = 0;
        valid_run = 0;
      end else begin
        if ($countones(trig_out) > 1) onehot_viol++;
        if (|trig_out) trig_run++;
        else if (trig_run != 0) begin
          trig_pulses++;
          if (trig_run != 5) trig_bad++;
          trig_run = 0;
        end
        if (sample_valid) begin
          valid_cnt++;
          valid_run++;
          if (valid_run > 1) valid_long++;
        end else valid_run = 0;
        if (scan_watch && !busy) busy_drop++;
      end
    end
  end

  typedef struct {
    int      len;
    int      ch;
    int      w;
    int      avg;
    int      to;
  } vec_t;

  vec_t tab[12];

  task automatic wait_sample(output int s_ch, output int s_w, output int s_avg,
                             output int s_to, output bit ok);
    int n;
    n = 0; ok = 1'b0; s_ch = 0; s_w = 0; s_avg = 0; s_to = 0;
    while (!ok && n < 5000) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1; s_ch = int'(ch_id); s_w = int'(width_ticks);
        s_avg = int'(avg_ticks); s_to = int'(sample_timeout);
      end
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s_ch, s_w, s_avg, s_to, n;
    bit ok;

    // ch, echo len, width, avg, timeout
    tab[0]  = '{len: 300,  ch: 0, w: 300, avg: 300, to: 0};
    tab[1]  = '{len: 400,  ch: 1, w: 400, avg: 400, to: 0};
    tab[2]  = '{len: 0,    ch: 2, w: 0,   avg: 0,   to: 1};
    tab[3]  = '{len: 100,  ch: 3, w: 100, avg: 100, to: 0};
    tab[4]  = '{len: 100,  ch: 0, w: 100, avg: 250, to: 0};
    tab[5]  = '{len: 800,  ch: 1, w: 800, avg: 500, to: 0};
    tab[6]  = '{len: 1200, ch: 2, w: 998, avg: 0,   to: 1};
    tab[7]  = '{len: 100,  ch: 3, w: 100, avg: 100, to: 0};
    tab[8]  = '{len: 800,  ch: 1, w: 800, avg: 575, to: 0};
    tab[9]  = '{len: 200,  ch: 3, w: 200, avg: 125, to: 0};
    tab[10] = '{len: 400,  ch: 1, w: 400, avg: 531, to: 0};
    tab[11] = '{len: 100,  ch: 3, w: 100, avg: 118, to: 0};

    rst_n = 1'b0; enable = 1'b0; ch_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_trig",    {28'd0, trig_out},        32'd0);
    chk("rst_ch_id",   {30'd0, ch_id},           32'd0);
    chk("rst_width",   {11'd0, width_ticks},     32'd0);
    chk("rst_avg",     {11'd0, avg_ticks},       32'd0);
    chk("rst_valid",   {31'd0, sample_valid},    32'd0);
    chk("rst_timeout", {31'd0, sample_timeout},  32'd0);
    chk("rst_busy",    {31'd0, busy},            32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_disabled_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) script.push_back(tab[i].len);
    ch_mask = 4'b1111;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    scan_watch = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (i == 7) begin
        // Drop enable while channel 3 is triggering: its ping must still complete.
        n = 0;
        while (!trig_out[3] && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("trig3_seen", {31'd0, trig_out[3]}, 32'd1);
        enable = 1'b0;
      end
      if (i == 8) begin
        scan_watch = 1'b0;
        wait_idle("disable_idle_busy");
        ch_mask = 4'b1010;
        enable  = 1'b1;
      end
      wait_sample(s_ch, s_w, s_avg, s_to, ok);
      chk($sformatf("vec%0d_arrived", i), {31'd0, ok}, 32'd1);
      chk($sformatf("vec%0d_ch_id", i),   s_ch,  tab[i].ch);
      chk($sformatf("vec%0d_width", i),   s_w,   tab[i].w);
      chk($sformatf("vec%0d_avg", i),     s_avg, tab[i].avg);
      chk($sformatf("vec%0d_timeout", i), s_to,  tab[i].to);
    end

    // Empty mask while enabled: scanner must fall back to idle and stay there.
    ch_mask = 4'b0000;
    wait_idle("mask0_idle_busy");
    repeat (50) @(negedge clk);
    chk("mask0_still_idle", {31'd0, busy}, 32'd0);
    chk("mask0_no_trig", {28'd0, trig_out}, 32'd0);
    chk("valid_count", valid_cnt, 32'd12);
    chk("busy_drop_in_scan", busy_drop, 32'd0);

    // Reset in the middle of a measurement on primed channel 0.
    script.push_back(500);
    ch_mask = 4'b1111;
    n = 0;
    while (!echo_in[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reset_ping_echo", {31'd0, echo_in[0]}, 32'd1);
    repeat (60) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_trig",  {28'd0, trig_out},     32'd0);
    chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
    chk("midrst_busy",  {31'd0, busy},         32'd0);
    chk("midrst_width", {11'd0, width_ticks},  32'd0);
    chk("midrst_avg",   {11'd0, avg_ticks},    32'd0);
    script.delete();
    for (int c = 0; c < 4; c++) resp_on[c] = 1'b0;
    echo_in = '0;
    repeat (3) @(negedge clk);
    script.push_back(700);
    rst_n = 1'b1;
    wait_sample(s_ch, s_w, s_avg, s_to, ok);
    chk("postrst_arrived", {31'd0, ok}, 32'd1);
    chk("postrst_ch_id",   s_ch,  32'd0);
    chk("postrst_width",   s_w,   32'd700);
    chk("postrst_avg",     s_avg, 32'd700);
    chk("postrst_timeout", s_to,  32'd0);

    repeat (5) @(negedge clk);
    chk("trig_len_bad",  trig_bad,    32'd0);
    chk("trig_pulses",   trig_pulses, 32'd14);
    chk("trig_onehot",   onehot_viol, 32'd0);
    chk("valid_1cycle",  valid_long,  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1, "global timeout");
  end

endmodule
